// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module : rf_pkg
// Brief  : Shared defaults, clear-sequencer state encoding and port-slice helpers
// Rev    : 1.0  initial release
// ============================================================================
package rf_pkg;

  localparam int RF_WIDTH_DEF = 16;
  localparam int RF_DEPTH_DEF = 8;
  localparam int RF_SELW_DEF  = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_t;

  // Low bit of read port `port` inside the packed select bus.
  function automatic int rd_sel_lo(input int port, input int selw);
    return port * selw;
  endfunction

  function automatic int rd_data_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dff.sv
`default_nettype none
// ============================================================================
// Module : dff
// Brief  : W-bit D flip-flop, asynchronous active-low reset to zero
// Rev    : 1.0  initial release
// ============================================================================
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_reg.sv
`default_nettype none
// ============================================================================
// Module : rf_reg
// Brief  : One WIDTH-wide storage word with load enable, built on the dff cell
// Rev    : 1.0  initial release
// ============================================================================
module rf_reg
  import rf_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] val_d;
  logic [WIDTH-1:0] val_q;

  always_comb begin
    val_d = en ? d : val_q;
  end

  dff #(
    .W (WIDTH)
  ) u_dff (
    .clk (clk),
    .rst (rst),
    .d   (val_d),
    .q   (val_q)
  );

  assign q = val_q;

endmodule
`default_nettype wire

// File: rtl/rf_param.sv
`default_nettype none
// ============================================================================
// Module : rf_param
// Brief  : Parametrised multi-read-port register file with hardware clear sweep.
//          Optional write-through bypass enabled by defining RF_BYPASS_EN.
// Rev    : 1.0  initial release
// ============================================================================
module rf_param
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH_DEF,
  parameter int DEPTH    = RF_DEPTH_DEF,
  parameter int SELW     = RF_SELW_DEF,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*SELW-1:0]   readregsel,
  output logic [NRD*WIDTH-1:0]  readdata,
  input  logic [SELW-1:0]       writeregsel,
  input  logic [WIDTH-1:0]      writedata,
  input  logic                  write,
  input  logic                  clr,
  output logic                  busy,
  output logic                  err
);

  localparam logic [SELW-1:0] PTR_LAST = SELW'(DEPTH - 1);

  rf_state_t        state_q;
  logic [SELW-1:0]  ptr_q;
  logic             busy_q;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wsel_ok;
  logic             wsel_zero;
  logic             wr_hit;
  logic [WIDTH-1:0] wr_data;
  logic [NRD-1:0]   rsel_oob;

  // Clear sequencer: one register zeroed per cycle, ptr sweeps 0..DEPTH-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clr) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (ptr_q == PTR_LAST) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            ptr_q   <= ptr_q + SELW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ptr_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    wsel_ok   = int'(writeregsel) < DEPTH;
    wsel_zero = (ZERO_REG != 0) && (writeregsel == '0);
    wr_hit    = write && (state_q == ST_IDLE) && wsel_ok && !wsel_zero;
    // The external write path is closed during a sweep, so zero is the only data then.
    wr_data   = (state_q == ST_CLEAR) ? '0 : writedata;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    logic wr_en;
    logic sw_en;

    assign wr_en = wr_hit && (int'(writeregsel) == i);
    assign sw_en = (state_q == ST_CLEAR) && (int'(ptr_q) == i);

    rf_reg #(
      .WIDTH (WIDTH)
    ) u_reg (
      .clk (clk),
      .rst (rst),
      .en  (wr_en | sw_en),
      .d   (wr_data),
      .q   (regs[i])
    );
  end

`ifdef RF_BYPASS_EN
  logic bypass_ok;
  assign bypass_ok = write && !busy_q && wsel_ok && !wsel_zero;
`endif

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [SELW-1:0]  sel;
    logic [WIDTH-1:0] data;

    assign sel         = readregsel[rd_sel_lo(k, SELW) +: SELW];
    assign rsel_oob[k] = int'(sel) >= DEPTH;

    always_comb begin
      data = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (int'(sel) == i) begin
          data = regs[i];
        end
      end
      if ((ZERO_REG != 0) && (sel == '0)) begin
        data = '0;
      end
`ifdef RF_BYPASS_EN
      if (bypass_ok && (sel == writeregsel)) begin
        data = writedata;
      end
`endif
    end

    assign readdata[rd_data_lo(k, WIDTH) +: WIDTH] = data;
  end

  assign busy = busy_q;
  assign err  = (write && !wsel_ok) || (|rsel_oob) || (write && busy_q);

endmodule
`default_nettype wire

// File: tb/tb_rf_param.sv
`default_nettype none
// ============================================================================
// Module : tb_rf_param
// Brief  : Self-checking bench for rf_param (default, DEPTH=6 and ZERO_REG=1 builds)
// Rev    : 1.0  initial release
// ============================================================================
module tb_rf_param;

  localparam int W = 16;
  localparam int D = 8;
  localparam int S = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: default geometry, reference-model checked
  logic [2*S-1:0] rsel_a;
  logic [2*W-1:0] rdata_a;
  logic [S-1:0]   wsel_a;
  logic [W-1:0]   wdata_a;
  logic           write_a, clr_a, busy_a, err_a;

  rf_param #(.WIDTH(W), .DEPTH(D), .SELW(S), .NRD(2), .ZERO_REG(0)) u_dut_a (
    .clk(clk), .rst(rst), .readregsel(rsel_a), .readdata(rdata_a),
    .writeregsel(wsel_a), .writedata(wdata_a), .write(write_a),
    .clr(clr_a), .busy(busy_a), .err(err_a));

  // Instance B: non-power-of-2 depth
  logic [2*S-1:0] rsel_b;
  logic [2*W-1:0] rdata_b;
  logic [S-1:0]   wsel_b;
  logic [W-1:0]   wdata_b;
  logic           write_b, clr_b, busy_b, err_b;

  rf_param #(.WIDTH(W), .DEPTH(6), .SELW(S), .NRD(2), .ZERO_REG(0)) u_dut_b (
    .clk(clk), .rst(rst), .readregsel(rsel_b), .readdata(rdata_b),
    .writeregsel(wsel_b), .writedata(wdata_b), .write(write_b),
    .clr(clr_b), .busy(busy_b), .err(err_b));

  // Instance C: hardwired zero register
  logic [2*S-1:0] rsel_c;
  logic [2*W-1:0] rdata_c;
  logic [S-1:0]   wsel_c;
  logic [W-1:0]   wdata_c;
  logic           write_c, clr_c, busy_c, err_c;

  rf_param #(.WIDTH(W), .DEPTH(D), .SELW(S), .NRD(2), .ZERO_REG(1)) u_dut_c (
    .clk(clk), .rst(rst), .readregsel(rsel_c), .readdata(rdata_c),
    .writeregsel(wsel_c), .writedata(wdata_c), .write(write_c),
    .clr(clr_c), .busy(busy_c), .err(err_c));

  // Reference model for instance A: contents array plus sweep progress.
  logic [W-1:0] m_mem [D];
  bit           m_busy;
  int           m_ptr;

  function void model_reset();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_busy = 1'b0;
    m_ptr  = 0;
  endfunction

  function void model_edge();
    if (m_busy) begin
      m_mem[m_ptr] = '0;
      m_ptr++;
      if (m_ptr == D) begin
        m_busy = 1'b0;
        m_ptr  = 0;
      end
    end else begin
      if (write_a && int'(wsel_a) < D) m_mem[wsel_a] = wdata_a;
      if (clr_a) begin
        m_busy = 1'b1;
        m_ptr  = 0;
      end
    end
  endfunction

  function automatic logic [W-1:0] exp_read(input int sel);
    if (sel >= D) return '0;
`ifdef RF_BYPASS_EN
    if (write_a && !m_busy && int'(wsel_a) == sel) return wdata_a;
`endif
    return m_mem[sel];
  endfunction

  task tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task test_reset();
    rst = 1'b0;
    rsel_a = '0; wsel_a = '0; wdata_a = '0; write_a = 1'b0; clr_a = 1'b0;
    rsel_b = '0; wsel_b = '0; wdata_b = '0; write_b = 1'b0; clr_b = 1'b0;
    rsel_c = '0; wsel_c = '0; wdata_c = '0; write_c = 1'b0; clr_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rsel_a = {3'd1, 3'd0};
    #1;
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_a); end
    n_cmp++; if (rdata_a !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata_a); end
    rst = 1'b1;
    #1;
  endtask

  task test_basic();
    wsel_a = 3'd3; wdata_a = 16'hBEEF; write_a = 1'b1;
    rsel_a = {3'd2, 3'd3};
    #1;
    tick();
    write_a = 1'b0;
    #1;
    n_cmp++; if (rdata_a[15:0] !== 16'hBEEF) begin n_bad++; $display("FAIL basic_p0: got %h want beef", rdata_a[15:0]); end
    n_cmp++; if (rdata_a[31:16] !== 16'h0000) begin n_bad++; $display("FAIL basic_p1: got %h want 0000", rdata_a[31:16]); end
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b want 0", err_a); end
  endtask

  task test_bypass();
    logic [W-1:0] exp0;
`ifdef RF_BYPASS_EN
    exp0 = 16'h00C3;
`else
    exp0 = 16'h0000;
`endif
    wsel_a = 3'd5; wdata_a = 16'h00C3; write_a = 1'b1;
    rsel_a = {3'd3, 3'd5};
    #1;
    n_cmp++; if (rdata_a[15:0] !== exp0) begin n_bad++; $display("FAIL bypass_same_cycle: got %h want %h", rdata_a[15:0], exp0); end
    n_cmp++; if (rdata_a[31:16] !== 16'hBEEF) begin n_bad++; $display("FAIL bypass_other_port: got %h want beef", rdata_a[31:16]); end
    tick();
    write_a = 1'b0;
    #1;
    n_cmp++; if (rdata_a[15:0] !== 16'h00C3) begin n_bad++; $display("FAIL bypass_next_cycle: got %h want 00c3", rdata_a[15:0]); end
  endtask

  task test_clear_sweep();
    int cyc;
    int nbusy;
    for (int i = 0; i < D; i++) begin
      wsel_a = 3'(i); wdata_a = 16'hA5A5; write_a = 1'b1;
      tick();
    end
    write_a = 1'b0; clr_a = 1'b1;
    rsel_a = {3'd1, 3'd0};
    #1;
    tick();
    clr_a = 1'b0;
    #1;
    cyc = 0;
    nbusy = 0;
    while (busy_a === 1'b1 && cyc < 20) begin
      cyc++;
      nbusy++;
      write_a = 1'b0; clr_a = 1'b0;
      if (cyc == 3) begin wsel_a = 3'd4; wdata_a = 16'h1234; write_a = 1'b1; end
      if (cyc == 4) clr_a = 1'b1;
      #1;
      if (cyc == 1) begin
        n_cmp++; if (rdata_a !== {16'hA5A5, 16'hA5A5}) begin n_bad++; $display("FAIL sweep_c1: got %h want a5a5a5a5", rdata_a); end
      end
      if (cyc == 2) begin
        n_cmp++; if (rdata_a !== {16'hA5A5, 16'h0000}) begin n_bad++; $display("FAIL sweep_c2: got %h want a5a50000", rdata_a); end
      end
      if (cyc == 3) begin
        n_cmp++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL sweep_write_err: got %b want 1", err_a); end
      end
      tick();
    end
    write_a = 1'b0; clr_a = 1'b0;
    n_cmp++; if (nbusy !== 8) begin n_bad++; $display("FAIL sweep_busy_cycles: got %0d want 8", nbusy); end
    for (int p = 0; p < D / 2; p++) begin
      rsel_a = {3'(2*p+1), 3'(2*p)};
      #1;
      n_cmp++; if (rdata_a !== 32'h0) begin n_bad++; $display("FAIL sweep_after_pair%0d: got %h want 0", p, rdata_a); end
    end
  endtask

  task test_zero_reg();
    wsel_c = 3'd0; wdata_c = 16'hFFFF; write_c = 1'b1;
    rsel_c = {3'd1, 3'd0};
    #1;
    n_cmp++; if (err_c !== 1'b0) begin n_bad++; $display("FAIL zero_write_err: got %b want 0", err_c); end
    n_cmp++; if (rdata_c[15:0] !== 16'h0) begin n_bad++; $display("FAIL zero_same_cycle: got %h want 0", rdata_c[15:0]); end
    tick();
    write_c = 1'b0;
    #1;
    n_cmp++; if (rdata_c[15:0] !== 16'h0) begin n_bad++; $display("FAIL zero_read: got %h want 0", rdata_c[15:0]); end
    wsel_c = 3'd1; wdata_c = 16'h5A5A; write_c = 1'b1;
    tick();
    write_c = 1'b0;
    #1;
    n_cmp++; if (rdata_c !== {16'h5A5A, 16'h0000}) begin n_bad++; $display("FAIL zero_reg1: got %h want 5a5a0000", rdata_c); end
  endtask

  task test_depth6();
    logic [W-1:0] exp6 [6];
    exp6[0] = '0; exp6[1] = 16'h1111; exp6[2] = '0; exp6[3] = '0; exp6[4] = '0; exp6[5] = 16'h5555;
    wsel_b = 3'd5; wdata_b = 16'h5555; write_b = 1'b1;
    tick();
    wsel_b = 3'd1; wdata_b = 16'h1111;
    tick();
    wsel_b = 3'd6; wdata_b = 16'h7777;
    rsel_b = {3'd1, 3'd0};
    #1;
    n_cmp++; if (err_b !== 1'b1) begin n_bad++; $display("FAIL d6_oob_write_err: got %b want 1", err_b); end
    tick();
    write_b = 1'b0;
    for (int p = 0; p < 3; p++) begin
      rsel_b = {3'(2*p+1), 3'(2*p)};
      #1;
      n_cmp++; if (rdata_b !== {exp6[2*p+1], exp6[2*p]}) begin n_bad++; $display("FAIL d6_contents_pair%0d: got %h want %h", p, rdata_b, {exp6[2*p+1], exp6[2*p]}); end
      n_cmp++; if (err_b !== 1'b0) begin n_bad++; $display("FAIL d6_inrange_err%0d: got %b want 0", p, err_b); end
    end
    rsel_b = {3'd5, 3'd7};
    #1;
    n_cmp++; if (rdata_b !== {16'h5555, 16'h0000}) begin n_bad++; $display("FAIL d6_oob_read: got %h want 55550000", rdata_b); end
    n_cmp++; if (err_b !== 1'b1) begin n_bad++; $display("FAIL d6_oob_read_err: got %b want 1", err_b); end
    rsel_b = {3'd5, 3'd5};
    #1;
    n_cmp++; if (err_b !== 1'b0) begin n_bad++; $display("FAIL d6_sel5_err: got %b want 0", err_b); end
  endtask

  task test_reset_mid_sweep();
    int guard;
    write_a = 1'b1; wsel_a = 3'd0; wdata_a = 16'h1111;
    tick();
    wsel_a = 3'd1; wdata_a = 16'h2222;
    tick();
    write_a = 1'b0; clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    tick();
    tick();
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy_a); end
    for (int p = 0; p < D / 2; p++) begin
      rsel_a = {3'(2*p+1), 3'(2*p)};
      #1;
      n_cmp++; if (rdata_a !== 32'h0) begin n_bad++; $display("FAIL midrst_pair%0d: got %h want 0", p, rdata_a); end
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    write_a = 1'b1; wsel_a = 3'd0; wdata_a = 16'h1111;
    tick();
    wsel_a = 3'd1; wdata_a = 16'h2222;
    tick();
    write_a = 1'b0; clr_a = 1'b1;
    rsel_a = {3'd1, 3'd0};
    tick();
    clr_a = 1'b0;
    #1;
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL restart_busy: got %b want 1", busy_a); end
    n_cmp++; if (rdata_a !== {16'h2222, 16'h1111}) begin n_bad++; $display("FAIL restart_c1: got %h want 22221111", rdata_a); end
    tick();
    #1;
    n_cmp++; if (rdata_a !== {16'h2222, 16'h0000}) begin n_bad++; $display("FAIL restart_c2: got %h want 22220000", rdata_a); end
    guard = 0;
    while (busy_a === 1'b1 && guard < 20) begin
      guard++;
      tick();
    end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL restart_busy_timeout: got %b want 0", busy_a); end
  endtask

  task test_random();
    logic [W-1:0] exp;
    for (int n = 0; n < 400; n++) begin
      write_a = ($urandom_range(0, 1) == 1);
      wsel_a  = 3'($urandom_range(0, 7));
      wdata_a = 16'($urandom);
      clr_a   = ($urandom_range(0, 24) == 0);
      rsel_a  = 6'($urandom);
      if ($urandom_range(0, 3) == 0) rsel_a[2:0] = wsel_a;
      #1;
      for (int k = 0; k < 2; k++) begin
        exp = exp_read(int'(rsel_a[k*S +: S]));
        n_cmp++; if (rdata_a[k*W +: W] !== exp) begin n_bad++; $display("FAIL rand_rd%0d n=%0d: got %h want %h", k, n, rdata_a[k*W +: W], exp); end
      end
      n_cmp++; if (err_a !== (write_a && m_busy)) begin n_bad++; $display("FAIL rand_err n=%0d: got %b want %b", n, err_a, write_a && m_busy); end
      n_cmp++; if (busy_a !== m_busy) begin n_bad++; $display("FAIL rand_busy n=%0d: got %b want %b", n, busy_a, m_busy); end
      tick();
    end
    write_a = 1'b0; clr_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_clear_sweep();
    test_zero_reg();
    test_depth6();
    test_reset_mid_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
